pixel_write_arbiter: RTL and testbench
======================================

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the address width of the requester ports and the master write address.
REQ-002 Parameter DATA_WIDTH, default 32, sets the data width of the requester ports and the master write data.
REQ-003 ACLK  input  1  is the single clock; all state changes on its rising edge.
REQ-004 ARESETn  input  1  is the synchronous, active-low reset, sampled on the ACLK rising edge.
REQ-005 req0, req1  input  1 each  are write requests from requester 0 and requester 1.
REQ-006 addr0, addr1  input  ADDR_WIDTH each  are the requester write addresses.
REQ-007 data0, data1  input  DATA_WIDTH each  are the requester write data.
REQ-008 ack0, ack1  output  1 each  are one-cycle completion pulses back to each requester.
REQ-009 err  output  1  is valid with an ack pulse; 1 means BRESP was not OKAY.
REQ-010 busy  output  1  is high in every state except IDLE.
REQ-011 oAWADDR  output  ADDR_WIDTH, oAWPROT  output  3, oAWVALID  output  1, oAWREADY  input  1 form the AXI4-Lite write address channel.
REQ-012 oWDATA  output  DATA_WIDTH, oWSTRB  output  DATA_WIDTH/8, oWVALID  output  1, oWREADY  input  1 form the write data channel.
REQ-013 oBRESP  input  2, oBVALID  input  1, oBREADY  output  1 form the write response channel.

Function
REQ-014 The FSM shall have three states: IDLE, XFER (AW/W outstanding) and RESP (waiting on B).
REQ-015 IDLE: if any reqN=1, grant it, latch its addrN/dataN into oAWADDR/oWDATA, and go to XFER on the next edge; otherwise stay in IDLE.
REQ-016 Arbitration: if only one request is high, grant it; if both are high, grant the requester not granted last (round-robin).
REQ-017 The last-grant pointer updates on every grant and resets to 1, so requester 0 wins the first contention.
REQ-018 XFER: oAWVALID and oWVALID rise together on entry; each drops independently the cycle after its own VALID&READY handshake.
REQ-019 XFER -> RESP on the edge after both handshakes have completed, whether they completed in the same cycle or different cycles.
REQ-020 The AW and W handshakes shall never be repeated within one transaction.
REQ-021 oBREADY shall be 1 only in RESP; an oBVALID seen outside RESP is ignored.
REQ-022 RESP: on oBVALID=1, go to IDLE; on the same edge pulse ackN of the granted requester for one cycle, with err = (oBRESP != 2'b00).
REQ-023 Only the granted requester's ack shall pulse, and ack0 and ack1 shall never be high together.
REQ-024 oAWPROT shall be constant 3'b010 and oWSTRB all ones.
REQ-025 oAWADDR and oWDATA shall hold their values from the grant until the next grant.
REQ-026 Requesters hold reqN, addrN and dataN until ackN; a reqN still high in the ack cycle is a new request, arbitrated in IDLE on the next cycle.
REQ-027 Zero-wait-state slave latency, reqN rise to ackN: 3 cycles (IDLE grant, XFER, RESP).
REQ-028 busy shall equal (state != IDLE).

Reset
REQ-029 When ARESETn=0 at a clock edge, the next state shall be IDLE, regardless of the current state.
REQ-030 Reset values: oAWVALID=0, oWVALID=0, oBREADY=0, ack0=ack1=0, err=0, busy=0, oAWADDR=0, oWDATA=0, last-grant pointer=1.
REQ-031 Reset mid-transaction abandons the transaction without an ack; the arbiter keeps no memory of it after reset.

Verification
REQ-032 Single write: req0=1, addr0=0x40, data0=0xFF, slave READY=1, BVALID one cycle after the handshake, BRESP=0 -> oAWADDR=0x40 and oWDATA=0xFF with both VALIDs for 1 cycle; ack0 pulses 3 cycles after req0 rises; err=0.
REQ-033 Contention: req0 and req1 both held high for 4 transactions -> grant order 0,1,0,1; no ack overlap; busy drops for 1 cycle between transactions.
REQ-034 Skewed handshake: oAWREADY=1 at cycle 1 and oWREADY=1 at cycle 4 -> oAWVALID low from cycle 2; oWVALID low after cycle 4; exactly one AW and one W handshake; RESP entered at cycle 5.
REQ-035 Error response: oBRESP=2'b10 with oBVALID -> ack1=1 and err=1 for exactly one cycle.
REQ-036 Stray response: oBVALID=1 while in IDLE -> oBREADY stays 0; no ack; state unchanged.
REQ-037 Reset in XFER: ARESETn=0 for 1 cycle while oAWVALID=1 -> all outputs at REQ-030 values after that edge; no ack; the next req0 is served normally.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// Two-requester round-robin arbiter that turns single-beat pixel writes into
// AXI4-Lite write transactions (AW + W, then wait for B) and acks the winner.
module pixel_write_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   data0,
    input  logic [DATA_WIDTH-1:0]   data1,
    output logic                    ack0,
    output logic                    ack1,
    output logic                    err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   oAWADDR,
    output logic [2:0]              oAWPROT,
    output logic                    oAWVALID,
    input  logic                    oAWREADY,
    output logic [DATA_WIDTH-1:0]   oWDATA,
    output logic [DATA_WIDTH/8-1:0] oWSTRB,
    output logic                    oWVALID,
    input  logic                    oWREADY,
    input  logic [1:0]              oBRESP,
    input  logic                    oBVALID,
    output logic                    oBREADY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_ack0;
    logic                    r_ack1;
    logic                    r_err;
    logic                    w_grant;
    logic                    w_xfer_done;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0 && req1) begin
            w_grant = ~r_last;
        end else if (req1) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // A channel counts as done once its VALID is low or is handshaking now.
    assign w_xfer_done = (~r_awvalid | oAWREADY) & (~r_wvalid | oWREADY);

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_next_state = ST_XFER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_xfer_done) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_XFER;
                end
            end
            ST_RESP: begin
                if (oBVALID) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant capture, channel VALIDs and the one-cycle ack/err pulse.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_last    <= 1'b1;
            r_awaddr  <= {ADDR_WIDTH{1'b0}};
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_last    <= w_grant;
                        r_awaddr  <= w_grant ? addr1 : addr0;
                        r_wdata   <= w_grant ? data1 : data0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (oAWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (oWREADY) begin
                        r_wvalid <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (oBVALID) begin
                        r_ack0 <= ~r_last;
                        r_ack1 <= r_last;
                        r_err  <= (oBRESP != 2'b00);
                    end
                end
                default: begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign err      = r_err;
    assign busy     = (r_state != ST_IDLE);
    assign oBREADY  = (r_state == ST_RESP);
    assign oAWADDR  = r_awaddr;
    assign oAWPROT  = 3'b010;
    assign oAWVALID = r_awvalid;
    assign oWDATA   = r_wdata;
    assign oWSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign oWVALID  = r_wvalid;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: inputs change and outputs are
// checked on the falling edge, so each negedge is one numbered cycle.
module tb_pixel_write_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req0, req1;
    logic [31:0] addr0, addr1, data0, data1;
    logic        ack0, ack1, err, busy;
    logic [31:0] oAWADDR;
    logic [2:0]  oAWPROT;
    logic        oAWVALID, oAWREADY;
    logic [31:0] oWDATA;
    logic [3:0]  oWSTRB;
    logic        oWVALID, oWREADY;
    logic [1:0]  oBRESP;
    logic        oBVALID, oBREADY;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int aw_base, w_base;

    pixel_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
        .oAWADDR(oAWADDR), .oAWPROT(oAWPROT), .oAWVALID(oAWVALID), .oAWREADY(oAWREADY),
        .oWDATA(oWDATA), .oWSTRB(oWSTRB), .oWVALID(oWVALID), .oWREADY(oWREADY),
        .oBRESP(oBRESP), .oBVALID(oBVALID), .oBREADY(oBREADY)
    );

    always #5 ACLK = ~ACLK;

    // Handshake monitor.
    always @(posedge ACLK) begin
        if (ARESETn && oAWVALID && oAWREADY) aw_hs_cnt <= aw_hs_cnt + 1;
        if (ARESETn && oWVALID && oWREADY)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    initial begin
        ARESETn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; data0 = 32'h0; data1 = 32'h0;
        oAWREADY = 1'b1; oWREADY = 1'b1; oBRESP = 2'b00; oBVALID = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_awvalid", oAWVALID, 1'b0);
        check_eq("rst_wvalid",  oWVALID,  1'b0);
        check_eq("rst_bready",  oBREADY,  1'b0);
        check_eq("rst_acks",    {ack0, ack1}, 2'b00);
        check_eq("rst_err",     err,  1'b0);
        check_eq("rst_busy",    busy, 1'b0);
        check_eq("rst_awaddr",  oAWADDR, 32'h0);
        check_eq("rst_wdata",   oWDATA,  32'h0);
        check_eq("awprot",      oAWPROT, 3'b010);
        check_eq("wstrb",       oWSTRB,  4'hF);
        ARESETn = 1'b1;
        tick();

        // Single write, zero-wait slave: ack0 three cycles after req0
        req0 = 1'b1; addr0 = 32'h40; data0 = 32'hFF;
        check_eq("t1_busy_c0", busy, 1'b0);
        tick();
        check_eq("t1_awvalid_c1", oAWVALID, 1'b1);
        check_eq("t1_wvalid_c1",  oWVALID,  1'b1);
        check_eq("t1_awaddr",     oAWADDR,  32'h40);
        check_eq("t1_wdata",      oWDATA,   32'hFF);
        check_eq("t1_busy_c1",    busy,     1'b1);
        check_eq("t1_bready_c1",  oBREADY,  1'b0);
        tick();
        check_eq("t1_valids_c2",  {oAWVALID, oWVALID}, 2'b00);
        check_eq("t1_bready_c2",  oBREADY, 1'b1);
        check_eq("t1_ack_c2",     {ack0, ack1}, 2'b00);
        oBVALID = 1'b1; oBRESP = 2'b00;
        tick();
        check_eq("t1_acks_c3",    {ack0, ack1}, 2'b10);
        check_eq("t1_err_c3",     err, 1'b0);
        check_eq("t1_busy_c3",    busy, 1'b0);
        check_eq("t1_bready_c3",  oBREADY, 1'b0);
        check_eq("t1_awaddr_hold", oAWADDR, 32'h40);
        req0 = 1'b0; oBVALID = 1'b0;
        tick();
        check_eq("t1_acks_c4", {ack0, ack1}, 2'b00);

        // Stray response while idle is ignored
        oBVALID = 1'b1; oBRESP = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stray_bready", oBREADY, 1'b0);
            check_eq("stray_acks",   {ack0, ack1, err}, 3'b000);
            check_eq("stray_busy",   busy, 1'b0);
        end
        oBVALID = 1'b0; oBRESP = 2'b00;
        tick();

        // Error response on requester 1
        req1 = 1'b1; addr1 = 32'h80; data1 = 32'h1234;
        tick();
        check_eq("t3_awaddr", oAWADDR, 32'h80);
        check_eq("t3_wdata",  oWDATA,  32'h1234);
        tick();
        check_eq("t3_bready", oBREADY, 1'b1);
        oBVALID = 1'b1; oBRESP = 2'b10;
        tick();
        check_eq("t3_acks", {ack0, ack1}, 2'b01);
        check_eq("t3_err",  err, 1'b1);
        req1 = 1'b0; oBVALID = 1'b0; oBRESP = 2'b00;
        tick();
        check_eq("t3_acks_after", {ack0, ack1}, 2'b00);
        check_eq("t3_err_after",  err, 1'b0);

        // Contention: both held, slave always responding -> order 0,1,0,1
        oBVALID = 1'b1;
        req0 = 1'b1; addr0 = 32'h100; data0 = 32'hA0;
        req1 = 1'b1; addr1 = 32'h200; data1 = 32'hB1;
        check_eq("rr_busy_start", busy, 1'b0);
        for (int t = 0; t < 4; t++) begin
            logic g;
            g = t[0];
            tick();
            check_eq("rr_awaddr", oAWADDR, g ? 32'h200 : 32'h100);
            check_eq("rr_wdata",  oWDATA,  g ? 32'hB1  : 32'hA0);
            check_eq("rr_busy_xfer", busy, 1'b1);
            tick();
            check_eq("rr_bready", oBREADY, 1'b1);
            check_eq("rr_ack_early", {ack0, ack1}, 2'b00);
            tick();
            check_eq("rr_acks", {ack0, ack1}, g ? 2'b01 : 2'b10);
            check_eq("rr_busy_gap", busy, 1'b0);
            if (t == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        tick();
        check_eq("rr_idle_after", {busy, ack0, ack1}, 3'b000);
        oBVALID = 1'b0;

        // Skewed handshake: AWREADY from cycle 1, WREADY from cycle 4
        oAWREADY = 1'b0; oWREADY = 1'b0;
        aw_base = aw_hs_cnt; w_base = w_hs_cnt;
        req0 = 1'b1; addr0 = 32'h44; data0 = 32'h55;
        tick();
        check_eq("sk_c1_valids", {oAWVALID, oWVALID}, 2'b11);
        oAWREADY = 1'b1;
        tick();
        check_eq("sk_c2_valids", {oAWVALID, oWVALID}, 2'b01);
        tick();
        check_eq("sk_c3_valids", {oAWVALID, oWVALID}, 2'b01);
        check_eq("sk_c3_bready", oBREADY, 1'b0);
        tick();
        check_eq("sk_c4_valids", {oAWVALID, oWVALID}, 2'b01);
        check_eq("sk_c4_bready", oBREADY, 1'b0);
        oWREADY = 1'b1;
        tick();
        check_eq("sk_c5_valids", {oAWVALID, oWVALID}, 2'b00);
        check_eq("sk_c5_bready", oBREADY, 1'b1);
        oBVALID = 1'b1;
        tick();
        check_eq("sk_acks", {ack0, ack1, err}, 3'b100);
        check_eq("sk_aw_hs_count", aw_hs_cnt - aw_base, 1);
        check_eq("sk_w_hs_count",  w_hs_cnt - w_base, 1);
        req0 = 1'b0; oBVALID = 1'b0;
        tick();

        // Reset in XFER, then contention must favour requester 0 again
        oAWREADY = 1'b0; oWREADY = 1'b0;
        req0 = 1'b1; addr0 = 32'h60; data0 = 32'h66;
        tick();
        check_eq("rx_awvalid", oAWVALID, 1'b1);
        ARESETn = 1'b0;
        tick();
        check_eq("rx_valids", {oAWVALID, oWVALID, oBREADY}, 3'b000);
        check_eq("rx_acks",   {ack0, ack1, err, busy}, 4'b0000);
        check_eq("rx_awaddr", oAWADDR, 32'h0);
        check_eq("rx_wdata",  oWDATA,  32'h0);
        ARESETn = 1'b1; oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b1;
        addr0 = 32'h70; data0 = 32'h77;
        req1 = 1'b1; addr1 = 32'h90; data1 = 32'h99;
        tick();
        check_eq("rx_regrant_addr", oAWADDR, 32'h70);
        check_eq("rx_acks_xfer", {ack0, ack1}, 2'b00);
        tick();
        check_eq("rx_bready", oBREADY, 1'b1);
        tick();
        check_eq("rx_ack_served", {ack0, ack1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0; oBVALID = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
